// File: rtl/beacon_energy_detector.sv
// Squares the 24-bit signed beacon stream, integrates energy over fixed windows of
// enabled samples, and runs a lock/fade hysteresis FSM to produce beacon_detect.
module beacon_energy_detector #(
  parameter int WINDOW   = 40,
  parameter int ACC_W    = 54,
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 2
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    enable,
  input  logic signed [23:0]      BeaconData_in,
  input  logic        [ACC_W-1:0] Threshold,
  output logic        [ACC_W-1:0] Energy_out,
  output logic                    energy_valid,
  output logic                    beacon_detect,
  output logic        [1:0]       state_out
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2,
    FADE    = 2'd3
  } state_t;

  state_t             state;
  logic signed [47:0] samp_ext;
  logic signed [47:0] prod;
  logic        [47:0] sq;
  logic               sq_v;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         hits;
  logic [2:0]         misses;
  logic               hit;

  // Square at full 48-bit width so (-2^23)^2 = 2^46 stays exact and positive.
  always_comb begin
    samp_ext = 48'(BeaconData_in);
    prod     = samp_ext * samp_ext;
    hit      = (Energy_out >= Threshold);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sq   <= '0;
      sq_v <= 1'b0;
    end else begin
      sq_v <= enable;
      if (enable)
        sq <= unsigned'(prod);
    end
  end

  // Final add of a window goes straight to Energy_out while acc clears, so the
  // next window's first sample lands in an empty accumulator with no lost cycle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      acc          <= '0;
      cnt          <= '0;
      Energy_out   <= '0;
      energy_valid <= 1'b0;
    end else begin
      energy_valid <= 1'b0;
      if (sq_v) begin
        if (cnt == CNT_W'(WINDOW - 1)) begin
          Energy_out   <= acc + ACC_W'(sq);
          energy_valid <= 1'b1;
          acc          <= '0;
          cnt          <= '0;
        end else begin
          acc <= acc + ACC_W'(sq);
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state         <= SEARCH;
      hits          <= '0;
      misses        <= '0;
      beacon_detect <= 1'b0;
    end else if (energy_valid) begin
      case (state)
        SEARCH: begin
          if (hit) begin
            if (LOCK_CNT == 1) begin
              state         <= LOCKED;
              hits          <= '0;
              beacon_detect <= 1'b1;
            end else begin
              state <= CONFIRM;
              hits  <= 3'd1;
            end
          end
        end
        CONFIRM: begin
          if (hit) begin
            if ((hits + 3'd1) == 3'(LOCK_CNT)) begin
              state         <= LOCKED;
              hits          <= '0;
              beacon_detect <= 1'b1;
            end else begin
              hits <= hits + 3'd1;
            end
          end else begin
            state <= SEARCH;
            hits  <= '0;
          end
        end
        LOCKED: begin
          if (!hit) begin
            if (LOSS_CNT == 1) begin
              state         <= SEARCH;
              misses        <= '0;
              beacon_detect <= 1'b0;
            end else begin
              state  <= FADE;
              misses <= 3'd1;
            end
          end
        end
        FADE: begin
          if (hit) begin
            state  <= LOCKED;
            misses <= '0;
          end else if ((misses + 3'd1) == 3'(LOSS_CNT)) begin
            state         <= SEARCH;
            misses        <= '0;
            beacon_detect <= 1'b0;
          end else begin
            misses <= misses + 3'd1;
          end
        end
        default: begin
          state         <= SEARCH;
          beacon_detect <= 1'b0;
        end
      endcase
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_beacon_energy_detector.sv
// Directed self-checking bench for beacon_energy_detector with hand-computed
// window energies and hysteresis state sequences.
module tb_beacon_energy_detector;

  logic               Clk;
  logic               Rst;
  logic               enable;
  logic signed [23:0] BeaconData_in;
  logic [53:0]        Threshold;
  logic [53:0]        Energy_out;
  logic               energy_valid;
  logic               beacon_detect;
  logic [1:0]         state_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  beacon_energy_detector #(
    .WINDOW  (40),
    .ACC_W   (54),
    .LOCK_CNT(3),
    .LOSS_CNT(2)
  ) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .enable       (enable),
    .BeaconData_in(BeaconData_in),
    .Threshold    (Threshold),
    .Energy_out   (Energy_out),
    .energy_valid (energy_valid),
    .beacon_detect(beacon_detect),
    .state_out    (state_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Feeds one window; returns positioned just after the evaluation edge (k+2).
  task automatic run_window(input string tag, input int amp, input bit gap,
                            input logic [53:0] exp_e);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      BeaconData_in = 24'(amp);
      enable = 1'b1;
      tick();
      seen |= energy_valid;
      if (gap && i < 39) begin
        enable = 1'b0;
        tick();
        seen |= energy_valid;
      end
    end
    enable = 1'b0;
    check({tag, "_early_valid"}, 64'(seen), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(energy_valid), 64'd1);
    check({tag, "_energy"}, 64'(Energy_out), 64'(exp_e));
    tick();
    check({tag, "_valid_drop"}, 64'(energy_valid), 64'd0);
  endtask

  task automatic pulse_reset();
    enable = 1'b0;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    tick();
  endtask

  initial begin
    logic seen;
    int   pulses;
    int   first_c;
    int   second_c;

    Rst = 1'b1;
    enable = 1'b1;
    BeaconData_in = '0;
    Threshold = '1;

    // Reset held with live data
    for (int i = 0; i < 6; i++) begin
      BeaconData_in = 24'($urandom);
      tick();
    end
    check("rst_energy", 64'(Energy_out), 64'd0);
    check("rst_valid", 64'(energy_valid), 64'd0);
    check("rst_detect", 64'(beacon_detect), 64'd0);
    check("rst_state", 64'(state_out), 64'd0);

    Rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 39; i++) begin
      BeaconData_in = 24'($urandom);
      enable = 1'b1;
      tick();
      seen |= energy_valid;
    end
    enable = 1'b0;
    tick();
    tick();
    check("partial_39_no_valid", 64'({seen, energy_valid}), 64'd0);
    pulse_reset();

    // Constant and full-scale windows (threshold max: FSM stays in SEARCH)
    run_window("pos1000", 1000, 1'b0, 54'd40000000);
    run_window("neg1000", -1000, 1'b0, 54'd40000000);
    run_window("fullscale", -8388608, 1'b0, 54'd2814749767106560);
    run_window("gaps", 1000, 1'b1, 54'd40000000);
    check("search_hold_state", 64'(state_out), 64'd0);

    // Back-to-back windows with enable held high
    pulses = 0;
    first_c = -1;
    second_c = -1;
    BeaconData_in = 24'sd1000;
    for (int c = 0; c < 86; c++) begin
      enable = (c < 80);
      tick();
      if (energy_valid) begin
        pulses++;
        if (first_c < 0) first_c = c;
        else second_c = c;
      end
    end
    check("b2b_pulses", 64'(pulses), 64'd2);
    check("b2b_first", 64'(first_c), 64'd40);
    check("b2b_spacing", 64'(second_c - first_c), 64'd40);
    check("b2b_energy", 64'(Energy_out), 64'd40000000);

    // Hysteresis
    Threshold = 54'd1000000;
    run_window("h1", 1000, 1'b0, 54'd40000000);
    check("h1_state", 64'(state_out), 64'd1);
    check("h1_detect", 64'(beacon_detect), 64'd0);
    run_window("h2", 1000, 1'b0, 54'd40000000);
    check("h2_state", 64'(state_out), 64'd1);
    check("h2_detect", 64'(beacon_detect), 64'd0);
    run_window("h3", 1000, 1'b0, 54'd40000000);
    check("h3_state", 64'(state_out), 64'd2);
    check("h3_detect", 64'(beacon_detect), 64'd1);
    run_window("h4_zero", 0, 1'b0, 54'd0);
    check("h4_state", 64'(state_out), 64'd3);
    check("h4_detect", 64'(beacon_detect), 64'd1);
    run_window("h5", 1000, 1'b0, 54'd40000000);
    check("h5_state", 64'(state_out), 64'd2);
    run_window("h6_zero", 0, 1'b0, 54'd0);
    check("h6_state", 64'(state_out), 64'd3);
    check("h6_detect", 64'(beacon_detect), 64'd1);
    run_window("h7_zero", 0, 1'b0, 54'd0);
    check("h7_state", 64'(state_out), 64'd0);
    check("h7_detect", 64'(beacon_detect), 64'd0);

    // Threshold boundary: energy exactly equal counts as a hit
    Threshold = 54'd40000000;
    run_window("thr_eq", 1000, 1'b0, 54'd40000000);
    check("thr_eq_state", 64'(state_out), 64'd1);
    Threshold = 54'd40000001;
    run_window("thr_above", 1000, 1'b0, 54'd40000000);
    check("thr_above_state", 64'(state_out), 64'd0);

    // Mid-window reset while CONFIRM holds hits=1
    Threshold = 54'd1000000;
    run_window("pre_rst", 1000, 1'b0, 54'd40000000);
    check("pre_rst_state", 64'(state_out), 64'd1);
    for (int i = 0; i < 20; i++) begin
      BeaconData_in = 24'sd1000;
      enable = 1'b1;
      tick();
    end
    enable = 1'b0;
    Rst = 1'b1;
    #1;
    check("async_rst_state", 64'(state_out), 64'd0);
    tick();
    Rst = 1'b0;
    run_window("post_rst", 1000, 1'b0, 54'd40000000);
    check("post_rst_state", 64'(state_out), 64'd1);
    run_window("post_rst2", 1000, 1'b0, 54'd40000000);
    check("post_rst_hits_cleared", 64'(state_out), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
